// File: rtl/mconst_pkg.sv
// Shared definitions for the MCONST zero-extender and its narrowing counterpart.
// Both sides agree on the state encoding and the word/half widths.
package mconst_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

endpackage

// File: rtl/mconst_beat_counter.sv
// Wrap-around event counter with enable; rst_n clears it asynchronously.
module mconst_beat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mconst_split.sv
// Splits 32-bit words into 16-bit immediate beats, low half first; words with a
// zero upper half go out as a single zero-extend beat when COMPRESS is set.
module mconst_split
    import mconst_pkg::*;
#(
    parameter bit COMPRESS = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HALF_W-1:0] out_data,
    output logic              out_last,
    output logic              out_ext,
    output logic [CNT_W-1:0]  beat_count
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] hold_q;
    logic              comp_q;
    logic              final_beat;
    logic              in_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            comp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                hold_q <= in_data;
                comp_q <= COMPRESS && (in_data[WORD_W-1:HALF_W] == '0);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_ext    = 1'b0;
        final_beat = 1'b0;
        case (state_q)
            IDLE: ;
            SEND_LO: begin
                out_valid  = 1'b1;
                out_data   = hold_q[HALF_W-1:0];
                out_last   = comp_q;
                out_ext    = comp_q;
                final_beat = comp_q;
                if (out_ready) state_d = comp_q ? IDLE : SEND_HI;
            end
            SEND_HI: begin
                out_valid  = 1'b1;
                out_data   = hold_q[WORD_W-1:HALF_W];
                out_last   = 1'b1;
                final_beat = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accepting alongside the final beat's transfer removes the IDLE bubble.
        in_ready = (state_q == IDLE) || (final_beat && out_ready);
        in_xfer  = in_valid && in_ready;
        if (in_xfer) state_d = SEND_LO;
    end

    mconst_beat_counter #(.CNT_W(CNT_W)) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_valid && out_ready),
        .count (beat_count)
    );

endmodule

// File: tb/tb_mconst_split.sv
// Directed bench for mconst_split: one compressing instance and one that always
// emits two beats, checked against hand-computed beats and counts.
module tb_mconst_split;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [15:0] out_data, beat_count;
    logic        out_last, out_ext;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [31:0] b_in_data = '0;
    logic [15:0] b_out_data, b_beat_count;
    logic        b_out_last, b_out_ext;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_count = '0;

    always #5 clk = ~clk;

    mconst_split #(.COMPRESS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_ext(out_ext),
        .beat_count(beat_count)
    );

    mconst_split #(.COMPRESS(1'b0), .CNT_W(16)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .out_ext(b_out_ext),
        .beat_count(b_beat_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the main instance's beat outputs against {valid, data, last, ext}.
    task automatic expect_beat(input string name, input logic v, input logic [15:0] d,
                               input logic l, input logic e);
        vectors++;
        if ({out_valid, out_data, out_last, out_ext} !== {v, d, l, e}) begin
            miscompares++;
            $display("FAIL %s: got valid=%b data=%h last=%b ext=%b, want valid=%b data=%h last=%b ext=%b",
                     name, out_valid, out_data, out_last, out_ext, v, d, l, e);
        end
    endtask

    task automatic expect_count(input string name);
        vectors++;
        if (beat_count !== exp_count) begin
            miscompares++;
            $display("FAIL %s: beat_count got %0d want %0d", name, beat_count, exp_count);
        end
    endtask

    task automatic expect_ready(input string name, input logic r);
        vectors++;
        if (in_ready !== r) begin
            miscompares++;
            $display("FAIL %s: in_ready got %b want %b", name, in_ready, r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        expect_beat("reset_outputs", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_ready("reset_in_ready", 1'b1);
        expect_count("reset_count");
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_compressed();
        logic [31:0] rebuilt;
        in_valid = 1'b1; in_data = 32'h0000_2F12; out_ready = 1'b1;
        #1;
        expect_ready("comp_ready_idle", 1'b1);
        step();
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        #1;
        expect_beat("comp_beat", 1'b1, 16'h2F12, 1'b1, 1'b1);
        rebuilt = out_ext ? {16'h0000, out_data} : 32'hFFFF_FFFF;
        vectors++;
        if (rebuilt !== 32'h0000_2F12) begin
            miscompares++;
            $display("FAIL comp_rebuild: got %h want 00002f12", rebuilt);
        end
        step();
        exp_count = exp_count + 16'd1;
        expect_beat("comp_idle_after", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("comp_count");
    endtask

    task automatic test_split();
        in_valid = 1'b1; in_data = 32'h1234_9618; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        expect_beat("split_lo", 1'b1, 16'h9618, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 32'h0000_0777;
        #1;
        expect_ready("split_ready_lo", 1'b0);
        in_valid = 1'b0;
        step();
        exp_count = exp_count + 16'd1;
        expect_beat("split_hi", 1'b1, 16'h1234, 1'b1, 1'b0);
        expect_count("split_count_mid");
        step();
        exp_count = exp_count + 16'd1;
        expect_beat("split_idle_after", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("split_count");
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 32'h1234_9618; out_ready = 1'b0;
        step();
        in_data = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            #1;
            expect_beat($sformatf("bp_hold_%0d", i), 1'b1, 16'h9618, 1'b0, 1'b0);
            expect_ready($sformatf("bp_ready_%0d", i), 1'b0);
            expect_count($sformatf("bp_count_%0d", i));
            step();
        end
        out_ready = 1'b1;
        #1;
        expect_ready("bp_ready_nonfinal", 1'b0);
        step();
        exp_count = exp_count + 16'd1;
        expect_beat("bp_hi", 1'b1, 16'h1234, 1'b1, 1'b0);
        expect_ready("bp_ready_final", 1'b1);
        step();
        exp_count = exp_count + 16'd1;
        in_valid = 1'b0;
        #1;
        expect_beat("bp_waiting_word", 1'b1, 16'h0055, 1'b1, 1'b1);
        step();
        exp_count = exp_count + 16'd1;
        expect_beat("bp_idle_after", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("bp_count");
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3] = '{16'h0001, 16'h0002, 16'h0003};
        out_ready = 1'b1; in_valid = 1'b1; in_data = {16'h0000, words[0]};
        step();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) in_data = {16'h0000, words[i+1]};
            else       in_valid = 1'b0;
            #1;
            expect_beat($sformatf("b2b_beat_%0d", i), 1'b1, words[i], 1'b1, 1'b1);
            step();
            exp_count = exp_count + 16'd1;
        end
        expect_beat("b2b_idle_after", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("b2b_count");
    endtask

    task automatic test_zero_word();
        in_valid = 1'b1; in_data = 32'h0000_0000; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        expect_beat("zero_beat", 1'b1, 16'h0000, 1'b1, 1'b1);
        step();
        exp_count = exp_count + 16'd1;
        expect_count("zero_count");
    endtask

    task automatic test_no_compress();
        b_in_valid = 1'b1; b_in_data = 32'h0000_9618; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        #1;
        vectors++;
        if ({b_out_valid, b_out_data, b_out_last, b_out_ext} !== {1'b1, 16'h9618, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL nc_lo: got valid=%b data=%h last=%b ext=%b, want 1 9618 0 0",
                     b_out_valid, b_out_data, b_out_last, b_out_ext);
        end
        step();
        vectors++;
        if ({b_out_valid, b_out_data, b_out_last, b_out_ext} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL nc_hi: got valid=%b data=%h last=%b ext=%b, want 1 0000 1 0",
                     b_out_valid, b_out_data, b_out_last, b_out_ext);
        end
        step();
        vectors++;
        if (b_out_valid !== 1'b0 || b_beat_count !== 16'd2) begin
            miscompares++;
            $display("FAIL nc_done: got valid=%b count=%0d, want valid=0 count=2",
                     b_out_valid, b_beat_count);
        end
    endtask

    task automatic test_reset_mid_word();
        logic saw_old_hi;
        in_valid = 1'b1; in_data = 32'h1234_9618; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        expect_beat("rst_mid_lo", 1'b1, 16'h9618, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        exp_count = '0;
        expect_beat("rst_mid_dropped", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("rst_mid_count");
        step();
        rst_n = 1'b1;
        step();
        saw_old_hi = 1'b0;
        in_valid = 1'b1; in_data = 32'hABCD_0001;
        step();
        in_valid = 1'b0;
        #1;
        if (out_data === 16'h1234) saw_old_hi = 1'b1;
        expect_beat("rst_new_lo", 1'b1, 16'h0001, 1'b0, 1'b0);
        step();
        if (out_data === 16'h1234) saw_old_hi = 1'b1;
        expect_beat("rst_new_hi", 1'b1, 16'hABCD, 1'b1, 1'b0);
        step();
        exp_count = 16'd2;
        expect_beat("rst_new_idle", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_count("rst_new_count");
        vectors++;
        if (saw_old_hi !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stale_half: stale 1234 beat seen=%b want 0", saw_old_hi);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_compressed();
        test_split();
        test_backpressure();
        test_back_to_back();
        test_zero_word();
        test_no_compress();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
